mul_repeated_add: RTL
=====================

Name: mul_repeated_add

Overview:
- Unsigned multiplier that computes a*b by repeated addition: an FSM controller plus an accumulate/count datapath in one block.
- Sits beside the repeated-subtraction divider; it is the inverse arithmetic operation on the same start/done handshake.
- A divider's quotient and divisor can be fed back in to rebuild the dividend minus the remainder.

Parameters:
- W, 8, operand width in bits; product is 2*W bits.
- MIN_ITER, 1, 1 = iterate over the smaller operand and add the larger; 0 = always add a, b times.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a multiply; sampled at clk when state is IDLE or DONE.
- a  input  W  multiplicand, captured on the accepting edge only.
- b  input  W  multiplier, captured on the accepting edge only.
- product  output  2W  result; valid while done=1.
- done  output  1  registered; high in DONE state.
- busy  output  1  registered; high in RUN state.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, product=0, done=0, busy=0, internal addend=0, count=0.
- States are IDLE, RUN and DONE. Encoding is 2 bits; code 3 is illegal and recovers to IDLE on the next edge with all outputs at reset values.

IDLE:
- If start=1, capture operands and go to RUN.
- Capture: if MIN_ITER=1 and b>a, addend<=b and count<=a; otherwise addend<=a and count<=b.
- Also on capture: product<=0, busy<=1, done<=0.
- If start=0, stay in IDLE.

RUN:
- If count!=0: product<=product+addend and count<=count-1.
- If count==0: go to DONE with done<=1 and busy<=0.
- start is ignored throughout RUN. Operands are not re-sampled.

DONE:
- product holds and done stays 1.
- If start=1, behave exactly as IDLE accepting: recapture operands, done<=0, go to RUN. Back-to-back operations need no idle cycle.
- If start=0, stay in DONE indefinitely.

Latency:
- Let N = count loaded. N=min(a,b) when MIN_ITER=1, else N=b.
- done rises N+1 clocks after the accepting edge.
- Example: a=5, b=3 with MIN_ITER=1 gives N=3, so done goes high after the 4th edge.

Arithmetic:
- Accumulator is 2W bits, and the addend is zero-extended to 2W.
- The maximum result (2^W-1)^2 fits in 2W bits, so no overflow is possible.
- count is W bits and decrements only when nonzero, so it never wraps.

Boundaries:
- a=0 or b=0: with MIN_ITER=1, N=0 and done comes 1 cycle after accept with product=0.
- b=0 with MIN_ITER=0: also 1 cycle, product=0.
- a=0 with MIN_ITER=0: runs b cycles adding 0; product=0.
- a==b: addend=a, count=b.
- Reset mid-RUN: the operation aborts immediately and async, all outputs go to reset values, and the block waits for a fresh start.
- start held high continuously: a new operation is accepted on the cycle after each DONE entry, so done pulses for exactly 1 cycle per result.

Decomposition:
- Shared package mul_pkg holds:
  - the state typedef and encodings (IDLE=0, RUN=1, DONE=2);
  - the default width constant W_DEF=8.
- One sub-module is natural: mul_datapath.
  - It contains the addend, count and product registers, the 2W adder, the operand swap mux, and the count==0 compare flag (zero).
  - It is controlled by ld, add and clr strobes from the FSM in mul_repeated_add.
  - It uses the same clk/rst.

Test Plan:
- Basic, MIN_ITER=1: a=5, b=3, pulse start 1 cycle -> busy=1 for 4 cycles, then done=1 with product=15, held until next start.
- Swap, MIN_ITER=1 vs 0: a=2, b=200 -> MIN_ITER=1 gives done after 3 cycles; MIN_ITER=0 gives done after 201 cycles. Both give product=400.
- Zero operands: (a=0, b=77) and (a=77, b=0) -> done 1 cycle after accept with product=0; check the MIN_ITER=0 iteration count for a=0 is 78 cycles.
- Max values: a=255, b=255 -> product=65025 (0xFE01), done after 256 cycles, no wrap of count or product.
- Handshake: start held high through RUN with a and b changing every cycle -> result uses the operands captured at accept. Back-to-back run 6*7 then 9*9 -> done pulses 1 cycle each with products 42 then 81.
- Reset: assert rst mid-RUN between clock edges (a=10, b=20) -> product=0, done=0 and busy=0 immediately. After release with start=0 the block stays in IDLE. A new start with a=3, b=4 gives product=12.

Source files
------------

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the repeated-addition multiplier.
//   state_t : controller state encoding (IDLE=0, RUN=1, DONE=2; code 3 illegal)
//   W_DEF   : default operand width in bits
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul_pkg

// File: rtl/mul_datapath.sv
// -----------------------------------------------------------------------------
// mul_datapath
// Accumulate/count datapath for the repeated-addition multiplier.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   ld            : capture operands (with optional swap) and clear product
//   add           : add addend into product and decrement count
//   clr           : return all registers to their reset values
//   a, b          : W-bit operands
//   product       : 2W-bit accumulator
//   zero          : count == 0
// -----------------------------------------------------------------------------
module mul_datapath
    import mul_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MIN_ITER = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld,
    input  logic           add,
    input  logic           clr,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           zero
);

    logic [W-1:0] addend;
    logic [W-1:0] count;
    logic         swap;

    // Iterating over the smaller operand keeps the loop as short as possible.
    assign swap = (MIN_ITER == 1) && (b > a);
    assign zero = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addend  <= '0;
            count   <= '0;
            product <= '0;
        end else if (clr) begin
            addend  <= '0;
            count   <= '0;
            product <= '0;
        end else if (ld) begin
            addend  <= swap ? b : a;
            count   <= swap ? a : b;
            product <= '0;
        end else if (add && !zero) begin
            // Zero-extend the addend; (2^W-1)^2 always fits in 2W bits.
            product <= product + {{W{1'b0}}, addend};
            count   <= count - 1'b1;
        end
    end

endmodule : mul_datapath

// File: rtl/mul_repeated_add.sv
// -----------------------------------------------------------------------------
// mul_repeated_add
// Unsigned multiplier computing a*b by repeated addition with a start/done
// handshake. An operation takes N+1 clocks after the accepting edge, where
// N = min(a,b) when MIN_ITER=1, otherwise N = b.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   start     : request; accepted in IDLE or DONE
//   a, b      : W-bit operands, captured on the accepting edge only
//   product   : 2W-bit result, valid while done=1
//   done      : high in DONE
//   busy      : high in RUN
// -----------------------------------------------------------------------------
module mul_repeated_add
    import mul_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MIN_ITER = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           done,
    output logic           busy
);

    state_t state;
    logic   ld;
    logic   add;
    logic   clr;
    logic   zero;

    // DONE accepts exactly like IDLE so back-to-back operations need no gap.
    assign ld  = start && ((state == IDLE) || (state == DONE));
    assign add = (state == RUN) && !zero;
    // The unused code 3 also wipes the datapath so recovery looks like reset.
    assign clr = (state != IDLE) && (state != RUN) && (state != DONE);

    mul_datapath #(
        .W        (W),
        .MIN_ITER (MIN_ITER)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .add     (add),
        .clr     (clr),
        .a       (a),
        .b       (b),
        .product (product),
        .zero    (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    // start is ignored here; the loop ends once count drains.
                    if (zero) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : mul_repeated_add
